// File: rtl/mult4_share_arbiter.sv
// Round-robin arbiter sharing one 4x4 signed multiplier among N_REQ requesters.
// Each accepted request produces one registered, ID-tagged product on a shared response channel.

module Multiplier_4bits_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  // Sign-extend before multiplying so the product is computed at full 8-bit width
  assign p_o = $signed({{4{a_i[3]}}, a_i}) * $signed({{4{b_i[3]}}, b_i});

endmodule

module mult4_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     reqValid_i,
  output logic [N_REQ-1:0]     reqReady_o,
  input  logic [4*N_REQ-1:0]   reqA_i,
  input  logic [4*N_REQ-1:0]   reqB_i,
  output logic                 rspValid_o,
  input  logic                 rspReady_i,
  output logic [7:0]           rspC_o,
  output logic [ID_W-1:0]      rspId_o,
  output logic [15:0]          opCnt_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] opId_q;
  logic [3:0]      opA_q;
  logic [3:0]      opB_q;
  logic [7:0]      rspC_q;
  logic [ID_W-1:0] rspId_q;
  logic            rspValid_q;
  logic [15:0]     opCnt_q;

  logic            grantFound_d;
  logic [ID_W-1:0] grant_d;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] idx;
  logic [3:0]      selA_d;
  logic [3:0]      selB_d;
  logic [7:0]      product;

  // Scan downward so the requester closest above the pointer is the last (winning) match
  always_comb begin
    grantFound_d = 1'b0;
    grant_d      = '0;
    idx          = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (reqValid_i[idx]) begin
        grantFound_d = 1'b1;
        grant_d      = idx;
      end
    end
    ptr_d = ID_W'((int'(grant_d) + 1) % N_REQ);
  end

  always_comb begin
    selA_d = '0;
    selB_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_d == ID_W'(i)) begin
        selA_d = reqA_i[4*i +: 4];
        selB_d = reqB_i[4*i +: 4];
      end
    end
  end

  always_comb begin
    reqReady_o = '0;
    if (state_q == IDLE && grantFound_d && !rst_i) begin
      reqReady_o[grant_d] = 1'b1;
    end
  end

  Multiplier_4bits_4bits uMult (
    .a_i (opA_q),
    .b_i (opB_q),
    .p_o (product)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      opId_q     <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      rspC_q     <= '0;
      rspId_q    <= '0;
      rspValid_q <= 1'b0;
      opCnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantFound_d) begin
            opA_q   <= selA_d;
            opB_q   <= selB_d;
            opId_q  <= grant_d;
            ptr_q   <= ptr_d;
            state_q <= CALC;
          end
        end
        CALC: begin
          rspC_q     <= product;
          rspId_q    <= opId_q;
          rspValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (rspReady_i) begin
            rspValid_q <= 1'b0;
            if (opCnt_q != 16'hFFFF) begin
              opCnt_q <= opCnt_q + 16'd1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rspValid_o = rspValid_q;
  assign rspC_o     = rspC_q;
  assign rspId_o    = rspId_q;
  assign opCnt_o    = opCnt_q;

endmodule

// File: tb/tb_mult4_share_arbiter.sv
// Directed bench for mult4_share_arbiter: vector table of single operations plus
// hand-written round-robin, backpressure, mid-operation reset and saturation sequences.

module tb_mult4_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [15:0] reqA;
  logic [15:0] reqB;
  logic        rspValid;
  logic        rspReady;
  logic [7:0]  rspC;
  logic [1:0]  rspId;
  logic [15:0] opCnt;

  int          vecCount;
  int          missCount;
  logic [15:0] expCnt;

  typedef struct {
    int         port;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;
  } vec_t;

  vec_t vecs[8];

  mult4_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .reqValid_i (reqValid),
    .reqReady_o (reqReady),
    .reqA_i     (reqA),
    .reqB_i     (reqB),
    .rspValid_o (rspValid),
    .rspReady_i (rspReady),
    .rspC_o     (rspC),
    .rspId_o    (rspId),
    .opCnt_o    (opCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reqValid = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expCnt = '0;
  endtask

  // One complete operation on a single port with the consumer always ready
  task automatic applyStimulus(input int port, input logic [3:0] a, input logic [3:0] b,
                               input logic [7:0] c);
    @(negedge clk);
    reqValid = 4'(1 << port);
    reqA = {12'b0, a} << (4 * port);
    reqB = {12'b0, b} << (4 * port);
    #1;
    checkOutput("grant_onehot", 32'(reqReady), 32'(1 << port));
    @(posedge clk);
    @(negedge clk);
    reqValid = '0;
    checkOutput("calc_ready_low", 32'(reqReady), 0);
    checkOutput("calc_rsp_low", 32'(rspValid), 0);
    @(negedge clk);
    checkOutput("rsp_valid", 32'(rspValid), 1);
    checkOutput("rsp_c", 32'(rspC), 32'(c));
    checkOutput("rsp_id", 32'(rspId), 32'(port));
    @(negedge clk);
    if (expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
    checkOutput("op_cnt", 32'(opCnt), 32'(expCnt));
    checkOutput("rsp_valid_drop", 32'(rspValid), 0);
  endtask

  initial begin
    logic [7:0] rrC[4];
    int         n;
    int         lastCycle;
    int         highCount;

    vecCount  = 0;
    missCount = 0;
    expCnt    = '0;
    rst       = 1'b1;
    reqValid  = '0;
    reqA      = '0;
    reqB      = '0;
    rspReady  = 1'b1;

    vecs[0] = '{1, 4'd7, 4'd7, 8'h31};
    vecs[1] = '{0, 4'h8, 4'h8, 8'h40};
    vecs[2] = '{1, 4'h8, 4'd7, 8'hC8};
    vecs[3] = '{2, 4'hF, 4'hF, 8'h01};
    vecs[4] = '{3, 4'h0, 4'hB, 8'h00};
    vecs[5] = '{0, 4'd3, 4'hC, 8'hF4};
    vecs[6] = '{2, 4'h9, 4'd5, 8'hDD};
    vecs[7] = '{3, 4'd7, 4'h8, 8'hC8};

    // Reset values, with a request pending that must not be acknowledged
    @(negedge clk);
    @(negedge clk);
    reqValid = 4'b1111;
    #1;
    checkOutput("reset_ready", 32'(reqReady), 0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 0);
    checkOutput("reset_rsp_c", 32'(rspC), 0);
    checkOutput("reset_rsp_id", 32'(rspId), 0);
    checkOutput("reset_op_cnt", 32'(opCnt), 0);
    reqValid = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].c);
    end

    // All four ports valid continuously: grants 0,1,2,3,0,... one every 3 cycles
    doReset();
    rrC[0] = 8'hF4;
    rrC[1] = 8'hF6;
    rrC[2] = 8'hE8;
    rrC[3] = 8'hDC;
    reqA = {4'd6, 4'h8, 4'd5, 4'hD};
    reqB = {4'hA, 4'd3, 4'hE, 4'd4};
    reqValid = 4'b1111;
    n = 0;
    lastCycle = 0;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      @(negedge clk);
      if (rspValid) begin
        checkOutput("rr_id", 32'(rspId), 32'(n % 4));
        checkOutput("rr_c", 32'(rspC), 32'(rrC[n % 4]));
        if (n > 0) checkOutput("rr_spacing", 32'(cyc - lastCycle), 3);
        lastCycle = cyc;
        n++;
        if (n == 8) reqValid = '0;
      end
    end
    checkOutput("rr_count", 32'(n), 8);
    @(negedge clk);
    expCnt = 16'd8;
    checkOutput("rr_op_cnt", 32'(opCnt), 32'(expCnt));

    // Backpressure: response held while a second request waits
    doReset();
    rspReady = 1'b0;
    @(negedge clk);
    reqValid = 4'b0100;
    reqA = 16'h0300;
    reqB = 16'h0500;
    @(posedge clk);
    @(negedge clk);
    reqValid = 4'b0001;
    reqA = 16'h000E;
    reqB = 16'h0009;
    checkOutput("bp_calc_ready", 32'(reqReady), 0);
    @(negedge clk);
    checkOutput("bp_valid", 32'(rspValid), 1);
    checkOutput("bp_c", 32'(rspC), 32'h0F);
    checkOutput("bp_id", 32'(rspId), 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 32'(rspValid), 1);
      checkOutput("bp_hold_c", 32'(rspC), 32'h0F);
      checkOutput("bp_hold_id", 32'(rspId), 2);
      checkOutput("bp_hold_ready", 32'(reqReady), 0);
    end
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(rspValid), 0);
    checkOutput("bp_release_ready", 32'(reqReady), 32'b0001);
    checkOutput("bp_cnt1", 32'(opCnt), 1);
    @(posedge clk);
    @(negedge clk);
    reqValid = '0;
    @(negedge clk);
    checkOutput("bp2_valid", 32'(rspValid), 1);
    checkOutput("bp2_c", 32'(rspC), 32'h0E);
    checkOutput("bp2_id", 32'(rspId), 0);
    @(negedge clk);
    expCnt = 16'd2;
    checkOutput("bp_cnt2", 32'(opCnt), 32'(expCnt));

    // Asynchronous reset while the operation is in CALC
    @(negedge clk);
    reqValid = 4'b1000;
    reqA = 16'hB000;
    reqB = 16'h3000;
    @(posedge clk);
    @(negedge clk);
    reqValid = '0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(rspValid), 0);
    checkOutput("abort_c", 32'(rspC), 0);
    checkOutput("abort_id", 32'(rspId), 0);
    checkOutput("abort_cnt", 32'(opCnt), 0);
    checkOutput("abort_ready", 32'(reqReady), 0);
    @(negedge clk);
    rst = 1'b0;
    expCnt = '0;
    highCount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rspValid) highCount++;
    end
    checkOutput("abort_no_rsp", 32'(highCount), 0);
    applyStimulus(1, 4'd4, 4'd4, 8'h10);

    // Saturation of the operation counter
    @(negedge clk);
    force dut.opCnt_q = 16'hFFFE;
    #1;
    release dut.opCnt_q;
    expCnt = 16'hFFFE;
    applyStimulus(2, 4'd2, 4'd3, 8'h06);
    applyStimulus(0, 4'hE, 4'd2, 8'hFC);
    checkOutput("sat_hold", 32'(opCnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/mult4_share_arbiter.md
# mult4_share_arbiter

Time-shares one combinational 4x4 signed multiplier (Multiplier_4bits_4bits, 8-bit two's-complement product) between N_REQ requesters. Each requester has a valid/ready request channel. Round-robin arbitration selects one request at a time. Operands and product are registered, and the result goes out on a single shared response channel tagged with the requester index. The block sits between the operand-producing units and the shared multiplier datapath.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of requester index; must satisfy 2^ID_W >= N_REQ
- CLK  input  1  clock, rising edge
- RST  input  1  reset; asynchronous, active-high
- REQ_VALID  input  N_REQ  per-requester request valid
- REQ_READY  output  N_REQ  per-requester accept strobe (one-hot or zero)
- REQ_A  input  4*N_REQ  signed multiplicand; requester i uses bits [4i+3:4i]
- REQ_B  input  4*N_REQ  signed multiplier; requester i uses bits [4i+3:4i]
- RSP_VALID  output  1  product valid
- RSP_READY  input  1  consumer accepts product
- RSP_C  output  8  signed product A*B, two's complement
- RSP_ID  output  ID_W  index of the requester that owns RSP_C
- OP_CNT  output  16  completed-operation count, saturating at 0xFFFF

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, when any REQ_VALID is set:
  - Grant g = first set REQ_VALID bit, searching upward (with wrap) from priority pointer PTR.
  - REQ_READY[g]=1 combinationally, same cycle; all other REQ_READY bits are 0.
  - Latch REQ_A[g], REQ_B[g] and g into the operand registers.
  - Set PTR = (g+1) mod N_REQ, then go to CALC.
- IDLE with no REQ_VALID set: stay in IDLE; REQ_READY = 0.
- CALC: register the multiplier output from the latched operands into RSP_C, then go to DONE.
- DONE: RSP_VALID=1; RSP_C and RSP_ID held stable.
  - On RSP_VALID&&RSP_READY: increment OP_CNT (saturating) and go to IDLE.
  - Otherwise stay in DONE.
- REQ_READY is 0 in CALC and DONE. Requests are not accepted while an operation is outstanding.
- Requesters must hold REQ_VALID/REQ_A/REQ_B until REQ_READY; the block never drops an accepted request.
- Arithmetic: RSP_C = low 8 bits of sign(A)*sign(B); full range −8..7 × −8..7 is exact in 8 bits.
- Out-of-range requester bits (index >= N_REQ) do not exist; REQ_VALID width is exactly N_REQ.

## Timing
- Reset (asynchronous, any state): state=IDLE, PTR=0, REQ_READY=0, RSP_VALID=0, RSP_C=0, RSP_ID=0, OP_CNT=0, operand registers 0.
- Reset mid-operation aborts the operation. No response is issued for it, and it is not counted.
- Latency: request accepted at edge t (REQ_READY high in cycle t-1..t) → CALC in cycle t → RSP_VALID high from cycle t+1.
  - Minimum: 2 cycles from acceptance to RSP_VALID.
- Throughput: one operation per 3 cycles with RSP_READY held high.
  - Next accept can occur in the cycle after the DONE handshake.
- RSP_VALID stays high until accepted. RSP_C/RSP_ID do not change while RSP_VALID=1 and RSP_READY=0.
- Simultaneous requests: exactly one granted per IDLE cycle, per round-robin order. Losers keep REQ_VALID and are served in later rounds.
- Starvation bound: a continuously valid requester is granted within N_REQ grants.
- PTR wraps from N_REQ-1 to 0.
- OP_CNT at 0xFFFF stays at 0xFFFF.

## Test plan
- Reset then single request on port 1, A=7, B=7 → REQ_READY=0b0010 for one cycle; RSP_VALID 2 cycles later; RSP_C=0x31, RSP_ID=1, OP_CNT=1.
- Sign corners, RSP_READY tied high → each product has the correct RSP_C value:
  - −8×−8 → 0x40
  - −8×7 → 0xC8
  - −1×−1 → 0x01
  - 0×−5 → 0x00
  - 3×−4 → 0xF4
- All four ports valid continuously after reset → grant order 0,1,2,3,0,…; one response every 3 cycles; RSP_ID follows the same order.
- RSP_READY low for 5 cycles in DONE → RSP_VALID, RSP_C and RSP_ID held constant; REQ_READY stays 0; acceptance resumes after the handshake.
- RST asserted during CALC → all outputs at reset values asynchronously; no RSP_VALID for the aborted op; OP_CNT=0; the next request is granted normally.
- Force OP_CNT near saturation (or run 65536+ ops) → OP_CNT holds 0xFFFF.
